// File: rtl/parity_stream_checker.sv
// rtl/parity_stream_checker.sv - streaming per-word/per-frame parity checker with saturating error count
module parity_stream_checker #(
  parameter int WIDTH   = 8,
  parameter int ODD     = 0,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_par,
  output logic             out_err,
  output logic             out_last,
  output logic             frame_done,
  output logic             frame_par,
  output logic             frame_err,
  output logic             frame_ovf,
  output logic [LEN_W-1:0] frame_len,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic             ODD_B   = (ODD != 0);
  localparam logic [LEN_W-1:0] MAX_N   = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       state;
  logic             acc_x;
  logic             acc_e;
  logic [LEN_W-1:0] len;

  logic             accept;
  logic             word_x;
  logic             word_p;
  logic             word_err;
  logic [LEN_W-1:0] n;
  logic             close;

  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
    word_x   = ^in_data;
    word_p   = word_x ^ ODD_B;
    word_err = word_p ^ in_par;
    // len only counts words of an open frame, so IDLE always starts from one
    n        = (state == IDLE) ? LEN_W'(1) : len + LEN_W'(1);
    close    = in_last || (n == MAX_N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc_x      <= 1'b0;
      acc_e      <= 1'b0;
      len        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_par    <= 1'b0;
      out_err    <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_par  <= 1'b0;
      frame_err  <= 1'b0;
      frame_ovf  <= 1'b0;
      frame_len  <= '0;
      err_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
        out_par   <= word_p;
        out_err   <= word_err;
        out_last  <= close;
        if (close) begin
          state      <= IDLE;
          len        <= '0;
          acc_x      <= 1'b0;
          acc_e      <= 1'b0;
          frame_done <= 1'b1;
          frame_par  <= acc_x ^ word_x ^ ODD_B;
          frame_err  <= acc_e | word_err;
          frame_ovf  <= !in_last;
          frame_len  <= n;
        end else begin
          state <= RUN;
          len   <= n;
          acc_x <= acc_x ^ word_x;
          acc_e <= acc_e | word_err;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // clear wins over a same-cycle error so software never sees a stale increment
      if (clr_cnt) begin
        err_cnt <= '0;
      end else if (accept && word_err && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_stream_checker.sv
// tb/tb_parity_stream_checker.sv - randomized and directed bench for parity_stream_checker
module tb_parity_stream_checker;

  localparam int WIDTH   = 8;
  localparam int ODD     = 1;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_par;
  logic             out_err;
  logic             out_last;
  logic             frame_done;
  logic             frame_par;
  logic             frame_err;
  logic             frame_ovf;
  logic [LEN_W-1:0] frame_len;
  logic             clr_cnt;
  logic [CNT_W-1:0] err_cnt;

  int total = 0;
  int bad   = 0;

  // reference model: output slot, closed-frame record, open-frame word lists, counter
  logic             m_ov, m_par, m_err, m_last, m_fd, m_fpar, m_ferr, m_fovf, m_rdy;
  logic [WIDTH-1:0] m_data;
  int               m_flen;
  int               m_cnt;
  logic [WIDTH-1:0] q_d[$];
  logic             q_e[$];
  logic             s_rdy;

  always #5 clk = ~clk;

  parity_stream_checker #(
    .WIDTH(WIDTH), .ODD(ODD), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_par(in_par), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_par(out_par), .out_err(out_err), .out_last(out_last),
    .frame_done(frame_done), .frame_par(frame_par), .frame_err(frame_err),
    .frame_ovf(frame_ovf), .frame_len(frame_len), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
  );

  task automatic model_clear();
    m_ov = 0; m_data = '0; m_par = 0; m_err = 0; m_last = 0; m_fd = 0;
    m_fpar = 0; m_ferr = 0; m_fovf = 0; m_flen = 0; m_cnt = 0;
    q_d.delete(); q_e.delete();
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; in_data = '0; in_par = 0; in_last = 0; out_ready = 1; clr_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  // drive one cycle at the falling edge, advance the model at the rising edge
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic p,
                      input logic l, input logic ordy, input logic clr);
    logic acc, wp, we, close;
    int   n, ones;
    in_valid = v; in_data = d; in_par = p; in_last = l; out_ready = ordy; clr_cnt = clr;
    #1;
    s_rdy = in_ready;
    m_rdy = !m_ov || ordy;
    acc   = v && m_rdy;
    wp    = 1'(($countones(d) + ODD) % 2);
    we    = (wp != p);
    @(posedge clk);
    m_fd = 0;
    if (acc) begin
      q_d.push_back(d);
      q_e.push_back(we);
      n     = q_d.size();
      close = l || (n == MAX_LEN);
      m_ov = 1; m_data = d; m_par = wp; m_err = we; m_last = close;
      if (close) begin
        ones = ODD;
        m_ferr = 0;
        foreach (q_d[i]) ones += $countones(q_d[i]);
        foreach (q_e[i]) m_ferr = m_ferr | q_e[i];
        m_fpar = 1'(ones % 2);
        m_fovf = !l;
        m_flen = n;
        m_fd   = 1;
        q_d.delete(); q_e.delete();
      end
    end else if (ordy) begin
      m_ov = 0;
    end
    if (clr) m_cnt = 0;
    else if (acc && we && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if ({out_data, out_par, out_err, out_last} !== '0) begin bad++; $display("FAIL reset_out_fields got=%h exp=0", {out_data, out_par, out_err, out_last}); end
    total++; if ({frame_done, frame_par, frame_err, frame_ovf, frame_len} !== '0) begin bad++; $display("FAIL reset_frame_fields got=%h exp=0", {frame_done, frame_par, frame_err, frame_ovf, frame_len}); end
    total++; if (err_cnt !== '0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_single();
    do_reset();
    step(1, 8'h07, 1'b0, 1, 1, 0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h07) begin bad++; $display("FAIL single_data got=%0b/%h exp=1/07", out_valid, out_data); end
    total++; if (out_par !== m_par || out_err !== 1'b0) begin bad++; $display("FAIL single_par got=%0b/%0b exp=%0b/0", out_par, out_err, m_par); end
    total++; if (out_last !== 1'b1 || frame_done !== 1'b1) begin bad++; $display("FAIL single_last got=%0b/%0b exp=1/1", out_last, frame_done); end
    total++; if (frame_par !== m_fpar || frame_len !== LEN_W'(1) || frame_ovf !== 1'b0) begin bad++; $display("FAIL single_frame got=%0b/%0d/%0b exp=%0b/1/0", frame_par, frame_len, frame_ovf, m_fpar); end
    step(0, 8'h00, 0, 0, 1, 0);
    total++; if (frame_done !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%0b/%0b exp=0/0", frame_done, out_valid); end
  endtask

  task automatic test_odd_frame();
    logic [WIDTH-1:0] dv[3] = '{8'h00, 8'h01, 8'h03};
    logic             pv[3] = '{1'b1, 1'b1, 1'b0};
    logic             ep[3] = '{1'b1, 1'b0, 1'b1};
    logic             ee[3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, dv[i], pv[i], (i == 2), 1, 0);
      total++; if (out_par !== ep[i] || out_err !== ee[i]) begin bad++; $display("FAIL odd_word%0d got=%0b/%0b exp=%0b/%0b", i, out_par, out_err, ep[i], ee[i]); end
    end
    total++; if (frame_done !== 1'b1 || frame_par !== 1'b0 || frame_err !== 1'b1 || frame_len !== LEN_W'(3)) begin bad++; $display("FAIL odd_frame got=%0b/%0b/%0b/%0d exp=1/0/1/3", frame_done, frame_par, frame_err, frame_len); end
    total++; if (err_cnt !== CNT_W'(2)) begin bad++; $display("FAIL odd_err_cnt got=%0d exp=2", err_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1, 8'hA5, 1'b1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h3C, 1'b1, 1, 0, 0);
      total++; if (s_rdy !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%0b exp=0", i, s_rdy); end
      total++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_par !== m_par) begin bad++; $display("FAIL bp_hold%0d got=%0b/%h/%0b exp=1/a5/%0b", i, out_valid, out_data, out_par, m_par); end
    end
    step(1, 8'h3C, 1'b1, 1, 1, 0);
    total++; if (s_rdy !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b exp=1", s_rdy); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_last !== 1'b1) begin bad++; $display("FAIL bp_next_word got=%0b/%h/%0b exp=1/3c/1", out_valid, out_data, out_last); end
    total++; if (frame_len !== LEN_W'(2) || frame_done !== 1'b1) begin bad++; $display("FAIL bp_frame got=%0d/%0b exp=2/1", frame_len, frame_done); end
    step(0, 8'h00, 0, 0, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_max_len();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1, 8'($urandom), 1'($urandom), (i == 6), 1, 0);
      total++; if (out_last !== m_last || frame_done !== m_fd) begin bad++; $display("FAIL maxlen_word%0d got=%0b/%0b exp=%0b/%0b", i, out_last, frame_done, m_last, m_fd); end
      if (i == 4) begin
        total++; if (frame_ovf !== 1'b1 || frame_len !== LEN_W'(4) || frame_par !== m_fpar || frame_err !== m_ferr) begin bad++; $display("FAIL maxlen_cap got=%0b/%0d/%0b/%0b exp=1/4/%0b/%0b", frame_ovf, frame_len, frame_par, frame_err, m_fpar, m_ferr); end
      end
    end
    total++; if (frame_ovf !== 1'b0 || frame_len !== LEN_W'(2) || frame_par !== m_fpar) begin bad++; $display("FAIL maxlen_tail got=%0b/%0d/%0b exp=0/2/%0b", frame_ovf, frame_len, frame_par, m_fpar); end
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 8'h11, 1'b1, (i == 4), 1, 0);
    total++; if (frame_ovf !== 1'b0 || frame_len !== LEN_W'(4)) begin bad++; $display("FAIL maxlen_last_on_cap got=%0b/%0d exp=0/4", frame_ovf, frame_len); end
  endtask

  task automatic test_err_sat();
    int exp_cnt[5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h00, 1'b0, 0, 1, 0);
      total++; if (err_cnt !== CNT_W'(exp_cnt[i])) begin bad++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, err_cnt, exp_cnt[i]); end
    end
    step(1, 8'h00, 1'b0, 1, 1, 1);
    total++; if (err_cnt !== '0 || out_err !== 1'b1) begin bad++; $display("FAIL sat_clr got=%0d/%0b exp=0/1", err_cnt, out_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 8'h12, 1'b0, 0, 1, 0);
    step(1, 8'h34, 1'b1, 0, 0, 0);
    do_reset();
    total++; if ({out_valid, out_data, out_par, out_err, out_last, frame_done, frame_len, err_cnt} !== '0) begin bad++; $display("FAIL midrst_outputs got=%h exp=0", {out_valid, out_data, out_par, out_err, out_last, frame_done, frame_len, err_cnt}); end
    step(1, 8'h56, 1'b0, 1, 1, 0);
    total++; if (frame_done !== 1'b1 || frame_len !== LEN_W'(1) || frame_ovf !== 1'b0) begin bad++; $display("FAIL midrst_len got=%0b/%0d/%0b exp=1/1/0", frame_done, frame_len, frame_ovf); end
  endtask

  task automatic test_random();
    int errs_here;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      errs_here = bad;
      step(($urandom % 4) != 0, 8'($urandom), 1'($urandom), ($urandom % 4) == 0,
           ($urandom % 4) != 0, ($urandom % 20) == 0);
      total++; if (s_rdy !== m_rdy) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%0b exp=%0b", c, s_rdy, m_rdy); end
      total++; if (out_valid !== m_ov || frame_done !== m_fd || err_cnt !== CNT_W'(m_cnt)) begin bad++; $display("FAIL rnd_ctrl c=%0d got=%0b/%0b/%0d exp=%0b/%0b/%0d", c, out_valid, frame_done, err_cnt, m_ov, m_fd, m_cnt); end
      if (m_ov) begin
        total++; if (out_data !== m_data || out_par !== m_par || out_err !== m_err || out_last !== m_last) begin bad++; $display("FAIL rnd_word c=%0d got=%h/%0b/%0b/%0b exp=%h/%0b/%0b/%0b", c, out_data, out_par, out_err, out_last, m_data, m_par, m_err, m_last); end
      end
      total++; if (frame_par !== m_fpar || frame_err !== m_ferr || frame_ovf !== m_fovf || frame_len !== LEN_W'(m_flen)) begin bad++; $display("FAIL rnd_frame c=%0d got=%0b/%0b/%0b/%0d exp=%0b/%0b/%0b/%0d", c, frame_par, frame_err, frame_ovf, frame_len, m_fpar, m_ferr, m_fovf, m_flen); end
      if (bad - errs_here > 0 && bad > 20) break;
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_par = 0; in_last = 0; out_ready = 1; clr_cnt = 0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_single();
    test_odd_frame();
    test_backpressure();
    test_max_len();
    test_err_sat();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
